// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: captures a vector op, steps an external scalar ALU
// across the active lanes one per cycle, and holds the result until consumed.
module vec_alu_sequencer #(
    parameter int N     = 8,
    parameter int LANES = 4,
    parameter int VLW   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_ctrl,
    input  logic [VLW-1:0]       in_vl,
    input  logic [N*LANES-1:0]   in_va,
    input  logic [N*LANES-1:0]   in_vb,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [N-1:0]         alu_y,
    input  logic [3:0]           alu_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*LANES-1:0]   out_vy,
    output logic [3:0]           out_flags,
    output logic [4*LANES-1:0]   out_lane_flags,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [VLW-1:0]       k_q;
    logic [VLW-1:0]       vl_q;
    logic [3:0]           ctrl_q;
    logic [N*LANES-1:0]   va_q;
    logic [N*LANES-1:0]   vb_q;
    logic [N*LANES-1:0]   vy_q;
    logic [4*LANES-1:0]   lf_q;
    logic [3:0]           flags_q;
    logic                 out_valid_q;
    logic [VLW-1:0]       vl_eff_d;
    logic [3:0]           flags_d;

    // Clamp the requested vector length to the number of physical lanes.
    always_comb begin
        if (in_vl > VLW'(LANES)) begin
            vl_eff_d = VLW'(LANES);
        end else begin
            vl_eff_d = in_vl;
        end
    end

    // Fold the current lane's flags into the aggregate: Z is an AND, the rest OR.
    always_comb begin
        flags_d = {flags_q[3] | alu_flags[3],
                   flags_q[2] & alu_flags[2],
                   flags_q[1] | alu_flags[1],
                   flags_q[0] | alu_flags[0]};
    end

    // ALU operands are only driven while stepping through lanes.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'd0;
        if (state_q == RUN) begin
            alu_a    = va_q[k_q*N +: N];
            alu_b    = vb_q[k_q*N +: N];
            alu_ctrl = ctrl_q;
        end else begin
            alu_ctrl = 4'd0;
        end
    end

    // Sequencer FSM with capture, per-lane writeback and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            vl_q        <= '0;
            ctrl_q      <= 4'd0;
            va_q        <= '0;
            vb_q        <= '0;
            vy_q        <= '0;
            lf_q        <= '0;
            flags_q     <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_q  <= in_ctrl;
                        va_q    <= in_va;
                        vb_q    <= in_vb;
                        vl_q    <= vl_eff_d;
                        k_q     <= '0;
                        // Inactive lanes keep A; aggregate starts from the identity.
                        vy_q    <= in_va;
                        lf_q    <= '0;
                        flags_q <= 4'b0100;
                        if (vl_eff_d == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    vy_q[k_q*N +: N] <= alu_y;
                    lf_q[k_q*4 +: 4] <= alu_flags;
                    flags_q          <= flags_d;
                    k_q              <= k_q + VLW'(1);
                    if (k_q == vl_q - VLW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign out_valid      = out_valid_q;
    assign out_vy         = vy_q;
    assign out_flags      = flags_q;
    assign out_lane_flags = lf_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a small reference 8-bit ALU attached.
module tb_vec_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [2:0]  in_vl;
    logic [31:0] in_va;
    logic [31:0] in_vb;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_y;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vy;
    logic [3:0]  out_flags;
    logic [15:0] out_lane_flags;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    vec_alu_sequencer #(.N(8), .LANES(4), .VLW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_vl(in_vl),
        .in_va(in_va), .in_vb(in_vb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_vy(out_vy),
        .out_flags(out_flags), .out_lane_flags(out_lane_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: flags are {N, Z, C, V}; C on sub means no borrow.
    logic [8:0] alu_t;
    logic       alu_c;
    logic       alu_v;
    always_comb begin
        alu_t = 9'd0;
        alu_y = 8'h00;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_y = alu_t[7:0];
                alu_c = alu_t[8];
                alu_v = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            4'd1: begin
                alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                alu_y = alu_t[7:0];
                alu_c = alu_t[8];
                alu_v = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
            end
            4'd2:    alu_y = alu_a & alu_b;
            4'd3:    alu_y = alu_a | alu_b;
            4'd4:    alu_y = ~(alu_a | alu_b);
            4'd5:    alu_y = alu_a ^ alu_b;
            default: alu_y = 8'h00;
        endcase
        alu_flags = {alu_y[7], (alu_y == 8'h00), alu_c, alu_v};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [2:0]  vl;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vy;
        logic [15:0] lf;
        logic [3:0]  fl;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[6];

    task automatic run_vec(input vec_t v);
        int lat;
        in_valid = 1'b1;
        in_ctrl  = v.ctrl;
        in_vl    = v.vl;
        in_va    = v.va;
        in_vb    = v.vb;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_va    = 32'hDEADBEEF;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            chk("alu_ctrl_run", {28'd0, alu_ctrl}, {28'd0, v.ctrl});
            tick();
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("out_vy", out_vy, v.vy);
        chk("lane_flags", {16'd0, out_lane_flags}, {16'd0, v.lf});
        chk("out_flags", {28'd0, out_flags}, {28'd0, v.fl});
        chk("alu_idle_in_done", {20'd0, alu_ctrl, alu_a}, 32'd0);
        chk("busy_done", {30'd0, busy, in_ready}, 32'd2);
        // Hold the result with a competing op offered; it must be ignored.
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_vl    = 3'd1;
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_vy", out_vy, v.vy);
            chk("hold_lf", {16'd0, out_lane_flags}, {16'd0, v.lf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int acc[$];
        int cyc;
        int i;
        tbl[0] = '{4'd0, 3'd4, 32'h00057F02, 32'h00050402, 32'h000A8304, 16'h4090, 4'b1001, 4, 0};
        tbl[1] = '{4'd1, 3'd2, 32'h00000702, 32'h00000404, 32'h000003FE, 16'h0028, 4'b1010, 2, 0};
        tbl[2] = '{4'd5, 3'd0, 32'h11223344, 32'hAABBCCDD, 32'h11223344, 16'h0000, 4'b0100, 0, 0};
        tbl[3] = '{4'd3, 3'd7, 32'h0F00F0A5, 32'hF0000F5A, 32'hFF00FFFF, 16'h8488, 4'b1000, 4, 3};
        tbl[4] = '{4'd5, 3'd3, 32'h12345678, 32'h12FF00F0, 32'h12CB5688, 16'h0808, 4'b1000, 3, 0};
        tbl[5] = '{4'd0, 3'd1, 32'h000000FF, 32'h00000001, 32'h00000000, 16'h0006, 4'b0110, 1, 0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = 4'd0; in_vl = 3'd0; in_va = 32'd0; in_vb = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("rst_vy", out_vy, 32'd0);
        chk("rst_flags", {12'd0, out_lane_flags, out_flags}, 32'd0);
        chk("rst_alu", {20'd0, alu_ctrl, alu_a}, 32'd0);

        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // Reset while lane index 2 is being processed.
        in_valid = 1'b1; in_ctrl = 4'd0; in_vl = 3'd4;
        in_va = tbl[0].va; in_vb = tbl[0].vb;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_alu_a_lane2", {24'd0, alu_a}, 32'h05);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("mid_rst_vy", out_vy, 32'd0);
        chk("mid_rst_flags", {12'd0, out_lane_flags, out_flags}, 32'd0);
        chk("mid_rst_alu", {20'd0, alu_ctrl, alu_a}, 32'd0);
        i = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) i++;
        end
        chk("mid_rst_no_pulse", i, 0);

        // Back-to-back vl=1 ops with the consumer always ready.
        in_valid = 1'b1; in_ctrl = 4'd2; in_vl = 3'd1;
        in_va = 32'h0000000F; in_vb = 32'h000000FF;
        out_ready = 1'b1;
        cyc = 0;
        for (int c = 0; c < 8; c++) begin
            if (in_ready) acc.push_back(cyc);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", acc.size(), 3);
        if (acc.size() >= 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 3);
            chk("b2b_gap2", acc[2] - acc[1], 3);
        end else begin
            chk("b2b_gap_missing", acc.size(), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
